// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_run_ctrl_pkg: run-control state encodings, host commands, HALT opcode.
// Rev 1.0
// ---------------------------------------------------------------------------
package pipeline_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  // Shared with the IF/ID decoder that raises halt_seen.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  function automatic logic is_busy(state_t s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter: enabled up-counter with synchronous clear, sticks at all-ones.
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_run_ctrl: RUN/STEP/PAUSE/CLEAR sequencer for the 5-stage pipeline.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_op_i,
  output logic             cmd_ready_o,
  input  logic             halt_seen_i,
  output logic             pipe_enable_o,
  output logic             pipe_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int               DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] C_DRN_INIT = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             pipe_enable_q, busy_q, done_q, timeout_q, timeout_d;
  logic             clr_q, clr_d;
  logic             w_cmd_fire, w_halt, w_tmo_hit;

  assign cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_halt      = halt_seen_i && pipe_enable_q;
  assign w_tmo_hit   = (MAX_CYCLES != 0) && (cycle_count_o == C_TMO_LAST);

  // Within RUN a halt outranks the timeout, which outranks any host command.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    timeout_d   = timeout_q;
    clr_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          case (cmd_op_i)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_CLEAR: clr_d   = 1'b1;
            default:   ;
          endcase
        end
      end
      ST_RUN: begin
        if (w_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = C_DRN_INIT;
        end else if (w_tmo_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (w_cmd_fire && (cmd_op_i == CMD_PAUSE)) begin
          state_d = ST_IDLE;
        end else if (w_cmd_fire && (cmd_op_i == CMD_CLEAR)) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      ST_STEP: begin
        if (w_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = C_DRN_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (w_cmd_fire && (cmd_op_i == CMD_CLEAR)) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_d) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      pipe_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      clr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      pipe_enable_q <= is_busy(state_d);
      busy_q        <= is_busy(state_d);
      done_q        <= (state_d == ST_DONE);
      timeout_q     <= timeout_d;
      clr_q         <= clr_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pipe_enable_q),
    .clr_i   (clr_d),
    .count_o (cycle_count_o)
  );

  assign pipe_enable_o = pipe_enable_q;
  assign pipe_rst_o    = rst || clr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_run_ctrl: directed scenarios; expectations are queued against
// absolute cycle numbers and checked by an independent negedge monitor.
// ---------------------------------------------------------------------------
module tb_pipeline_run_ctrl;
  import pipeline_run_ctrl_pkg::*;

  localparam int CNT_W = 32;

  localparam int S_EN   = 0;
  localparam int S_PRST = 1;
  localparam int S_BUSY = 2;
  localparam int S_DONE = 3;
  localparam int S_TMO  = 4;
  localparam int S_CNT  = 5;
  localparam int S_RDY  = 6;

  typedef struct {
    int          at;
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic             halt_seen = 1'b0;
  logic             cmd_ready, pipe_enable, pipe_rst, busy, done, timeout;
  logic [CNT_W-1:0] cycle_count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  pipeline_run_ctrl #(
    .CNT_W        (CNT_W),
    .MAX_CYCLES   (20),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_op_i      (cmd_op),
    .cmd_ready_o   (cmd_ready),
    .halt_seen_i   (halt_seen),
    .pipe_enable_o (pipe_enable),
    .pipe_rst_o    (pipe_rst),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_o     (timeout),
    .cycle_count_o (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(int s);
    case (s)
      S_EN:    return {31'd0, pipe_enable};
      S_PRST:  return {31'd0, pipe_rst};
      S_BUSY:  return {31'd0, busy};
      S_DONE:  return {31'd0, done};
      S_TMO:   return {31'd0, timeout};
      S_CNT:   return cycle_count;
      default: return {31'd0, cmd_ready};
    endcase
  endfunction

  // Monitor: retire every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        checks = checks + 1;
        if (act(sbq[i].sig) !== sbq[i].val) begin
          failures = failures + 1;
          $display("FAIL %s cycle=%0d actual=%0d required=%0d",
                   sbq[i].name, cyc, act(sbq[i].sig), sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic ex(input int d, input string nm, input int s, input logic [31:0] v);
    exp_t e;
    e.at   = cyc + d;
    e.name = nm;
    e.sig  = s;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    go(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    halt_seen = 1'b0;
    go(2);
    ex(0, "rst_prst", S_PRST, 1);
    ex(0, "rst_en",   S_EN,   0);
    ex(0, "rst_busy", S_BUSY, 0);
    ex(0, "rst_done", S_DONE, 0);
    ex(0, "rst_tmo",  S_TMO,  0);
    ex(0, "rst_cnt",  S_CNT,  0);
    ex(0, "rst_rdy",  S_RDY,  1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    go(1);
    ex(0, "rst_release_prst", S_PRST, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Halt at enabled cycle 10 -> 14 enabled cycles then DONE.
    do_reset();
    ex(0,  "t1_rdy_idle",  S_RDY,  1);
    ex(1,  "t1_en_first",  S_EN,   1);
    ex(1,  "t1_cnt_first", S_CNT,  0);
    ex(1,  "t1_busy",      S_BUSY, 1);
    ex(10, "t1_cnt_c10",   S_CNT,  9);
    ex(12, "t1_rdy_drain", S_RDY,  0);
    ex(14, "t1_en_last",   S_EN,   1);
    ex(15, "t1_en_off",    S_EN,   0);
    ex(15, "t1_done",      S_DONE, 1);
    ex(15, "t1_cnt",       S_CNT,  14);
    ex(15, "t1_busy_off",  S_BUSY, 0);
    cmd(CMD_RUN);
    go(9);
    halt_seen = 1'b1;
    go(1);
    halt_seen = 1'b0;
    go(5);

    // Three single steps.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ex(0, "t2_en_pre",   S_EN,  0);
      ex(1, "t2_en_pulse", S_EN,  1);
      ex(1, "t2_rdy_step", S_RDY, 0);
      ex(2, "t2_en_post",  S_EN,  0);
      ex(2, "t2_cnt",      S_CNT, i + 1);
      cmd(CMD_STEP);
      go(2);
    end
    ex(0, "t2_cnt_final", S_CNT,  3);
    ex(0, "t2_busy",      S_BUSY, 0);
    ex(0, "t2_rdy_idle",  S_RDY,  1);
    go(1);

    // Timeout after 20 enabled cycles, RUN dropped in DONE, then CLEAR.
    do_reset();
    ex(20, "t3_en_20",       S_EN,   1);
    ex(20, "t3_tmo_pre",     S_TMO,  0);
    ex(20, "t3_cnt_19",      S_CNT,  19);
    ex(21, "t3_en_off",      S_EN,   0);
    ex(21, "t3_done",        S_DONE, 1);
    ex(21, "t3_tmo",         S_TMO,  1);
    ex(21, "t3_cnt_20",      S_CNT,  20);
    ex(22, "t6_rdy_done",    S_RDY,  1);
    ex(23, "t6_done_stay",   S_DONE, 1);
    ex(23, "t6_en_stay",     S_EN,   0);
    ex(23, "t6_cnt_stay",    S_CNT,  20);
    ex(25, "t3_prst_pulse",  S_PRST, 1);
    ex(25, "t3_cnt_clr",     S_CNT,  0);
    ex(25, "t3_tmo_clr",     S_TMO,  0);
    ex(25, "t3_done_clr",    S_DONE, 0);
    ex(25, "t3_en_clr",      S_EN,   0);
    ex(26, "t3_prst_end",    S_PRST, 0);
    ex(26, "t3_en_after",    S_EN,   0);
    cmd(CMD_RUN);
    go(21);
    cmd(CMD_RUN);
    go(1);
    cmd(CMD_CLEAR);
    go(3);

    // PAUSE in the halt cycle loses to the drain; command in DRAIN refused.
    do_reset();
    ex(3, "t4_rdy_run",   S_RDY,  1);
    ex(4, "t4_drain_en",  S_EN,   1);
    ex(4, "t4_busy",      S_BUSY, 1);
    ex(5, "t4_rdy_drain", S_RDY,  0);
    ex(7, "t4_en_last",   S_EN,   1);
    ex(8, "t4_en_off",    S_EN,   0);
    ex(8, "t4_done",      S_DONE, 1);
    ex(8, "t4_cnt",       S_CNT,  7);
    cmd(CMD_RUN);
    go(2);
    cmd_valid = 1'b1;
    cmd_op    = CMD_PAUSE;
    halt_seen = 1'b1;
    go(1);
    cmd_valid = 1'b0;
    halt_seen = 1'b0;
    go(1);
    cmd(CMD_RUN);
    go(3);

    // Plain PAUSE from RUN.
    do_reset();
    ex(3, "t7_en_off", S_EN,   0);
    ex(3, "t7_cnt",    S_CNT,  2);
    ex(3, "t7_busy",   S_BUSY, 0);
    ex(5, "t7_idle",   S_EN,   0);
    cmd(CMD_RUN);
    go(1);
    cmd(CMD_PAUSE);
    go(3);

    // rst with drain_cnt=2 aborts the drain.
    do_reset();
    ex(4, "t5_en_drain",  S_EN,   1);
    ex(4, "t5_prst_rst",  S_PRST, 1);
    ex(5, "t5_en_off",    S_EN,   0);
    ex(5, "t5_cnt",       S_CNT,  0);
    ex(5, "t5_busy",      S_BUSY, 0);
    ex(7, "t5_en_idle",   S_EN,   0);
    ex(7, "t5_done",      S_DONE, 0);
    cmd(CMD_RUN);
    go(1);
    halt_seen = 1'b1;
    go(1);
    halt_seen = 1'b0;
    go(1);
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    go(3);

    if (sbq.size() != 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
